mem_stage_ldx: RTL and testbench

Parametrised memory-access pipeline stage between EX and WB of the in-order CPU. It holds one instruction and waits for the data-SRAM response on loads. It extracts and sign- or zero-extends byte, half, word and double loads, and buffers a response that arrives while WB is stalled. It also supports a flush that cancels the resident instruction and discards its late memory response, and drives a forwarding and hazard port back to ID.

---
 rtl/mem_stage_ldx.sv | 144 ++++++++++++++
 tb/tb_mem_stage_ldx.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ldx.sv
// MEM stage: holds one instruction, waits for the data-SRAM load response, extracts and extends the load lane.
// Buffers a response that arrives while WB stalls, and counts responses orphaned by a flush so they can be dropped.
module mem_stage_ldx #(
  parameter int PC_W     = 32,
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int ES_BUS_W = PC_W + 1 + REG_AW + DATA_W + 3,
  parameter int WS_BUS_W = PC_W + 1 + REG_AW + DATA_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                es_to_ms_valid,
  input  logic [ES_BUS_W-1:0] es_to_ms_bus,
  output logic                ms_allowin,
  input  logic                ws_allowin,
  output logic                ms_to_ws_valid,
  output logic [WS_BUS_W-1:0] ms_to_ws_bus,
  input  logic                ms_flush,
  input  logic                data_sram_data_ok,
  input  logic [DATA_W-1:0]   data_sram_rdata,
  output logic [REG_AW-1:0]   ms_fwd_dest,
  output logic [DATA_W-1:0]   ms_fwd_data,
  output logic                ms_fwd_busy
);
  localparam int OFF_W = (DATA_W == 64) ? 3 : 2;

  logic              r_ms_valid;
  logic [PC_W-1:0]   r_pc;
  logic              r_gr_we;
  logic [REG_AW-1:0] r_dest;
  logic [DATA_W-1:0] r_alu_result;
  logic [2:0]        r_ld_op;
  logic              r_buf_valid;
  logic [DATA_W-1:0] r_rdata_buf;
  logic [1:0]        r_drop_cnt;

  logic [PC_W-1:0]   w_es_pc;
  logic              w_es_gr_we;
  logic [REG_AW-1:0] w_es_dest;
  logic [DATA_W-1:0] w_es_alu_result;
  logic [2:0]        w_es_ld_op;
  logic              w_is_load;
  logic              w_drop_zero;
  logic              w_resp_hit;
  logic              w_ready_go;
  logic              w_leave;
  logic              w_capture;
  logic              w_buf_set;
  logic              w_drop_inc;
  logic              w_drop_dec;
  logic [OFF_W-1:0]  w_off;
  logic [DATA_W-1:0] w_resp;
  logic [DATA_W-1:0] w_lane;
  logic [DATA_W-1:0] w_final;

  assign {w_es_pc, w_es_gr_we, w_es_dest, w_es_alu_result, w_es_ld_op} = es_to_ms_bus;

  // A data_ok is only ours when no flushed load still owes a response.
  assign w_is_load   = (r_ld_op != 3'd0);
  assign w_drop_zero = (r_drop_cnt == 2'd0);
  assign w_resp_hit  = r_buf_valid || (data_sram_data_ok && w_drop_zero);
  assign w_ready_go  = !w_is_load || w_resp_hit;
  assign ms_allowin  = !r_ms_valid || (w_ready_go && ws_allowin);
  assign w_leave     = r_ms_valid && w_ready_go && ws_allowin;
  assign w_capture   = ms_allowin && es_to_ms_valid && !ms_flush;
  assign w_buf_set   = r_ms_valid && w_is_load && !r_buf_valid && data_sram_data_ok
                       && w_drop_zero && !ws_allowin;
  assign w_drop_inc  = ms_flush && r_ms_valid && w_is_load && !w_resp_hit;
  assign w_drop_dec  = data_sram_data_ok && !w_drop_zero;

  assign w_off  = r_alu_result[OFF_W-1:0];
  assign w_resp = r_buf_valid ? r_rdata_buf : data_sram_rdata;
  assign w_lane = w_resp >> {w_off, 3'b000};

  always_comb begin
    w_final = r_alu_result;
    case (r_ld_op)
      3'd0:    w_final = r_alu_result;
      3'd1:    w_final = DATA_W'($signed(w_lane[7:0]));
      3'd2:    w_final = DATA_W'(w_lane[7:0]);
      3'd3:    w_final = DATA_W'($signed(w_lane[15:0]));
      3'd4:    w_final = DATA_W'(w_lane[15:0]);
      3'd5:    w_final = DATA_W'($signed(w_lane[31:0]));
      3'd6:    w_final = (DATA_W == 64) ? DATA_W'(w_lane[31:0]) : w_lane;
      3'd7:    w_final = w_lane;
      default: w_final = r_alu_result;
    endcase
  end

  assign ms_to_ws_valid = r_ms_valid && w_ready_go && !ms_flush;
  assign ms_to_ws_bus   = {r_pc, r_gr_we, r_dest, w_final};
  assign ms_fwd_dest    = (r_ms_valid && r_gr_we) ? r_dest : {REG_AW{1'b0}};
  assign ms_fwd_data    = w_final;
  assign ms_fwd_busy    = r_ms_valid && w_is_load && !w_resp_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ms_valid   <= 1'b0;
      r_pc         <= {PC_W{1'b0}};
      r_gr_we      <= 1'b0;
      r_dest       <= {REG_AW{1'b0}};
      r_alu_result <= {DATA_W{1'b0}};
      r_ld_op      <= 3'd0;
    end else begin
      if (ms_flush) begin
        r_ms_valid <= 1'b0;
      end else if (ms_allowin) begin
        r_ms_valid <= es_to_ms_valid;
      end
      if (w_capture) begin
        r_pc         <= w_es_pc;
        r_gr_we      <= w_es_gr_we;
        r_dest       <= w_es_dest;
        r_alu_result <= w_es_alu_result;
        r_ld_op      <= w_es_ld_op;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_buf_valid <= 1'b0;
      r_rdata_buf <= {DATA_W{1'b0}};
    end else if (ms_flush || w_leave) begin
      r_buf_valid <= 1'b0;
    end else if (w_buf_set) begin
      r_buf_valid <= 1'b1;
      r_rdata_buf <= data_sram_rdata;
    end
  end

  // Saturating count of responses still owed to flushed loads; inc and dec together cancel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_drop_cnt <= 2'd0;
    end else if (w_drop_inc && !w_drop_dec) begin
      if (r_drop_cnt != 2'd3) begin
        r_drop_cnt <= r_drop_cnt + 2'd1;
      end
    end else if (w_drop_dec && !w_drop_inc) begin
      r_drop_cnt <= r_drop_cnt - 2'd1;
    end
  end
endmodule

// File: tb/tb_mem_stage_ldx.sv
// Directed bench for mem_stage_ldx: a 32-bit instance driven from a vector table plus multi-cycle
// sequences, and a 64-bit instance for the doubleword and word-unsigned lanes.
module tb_mem_stage_ldx;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        es_valid, ms_allowin, ws_allowin, ms_to_ws_valid, ms_flush, data_ok, fwd_busy;
  logic [72:0] es_bus;
  logic [69:0] ws_bus;
  logic [31:0] rdata, fwd_data;
  logic [4:0]  fwd_dest;

  logic         es_valid64, ms_allowin64, ws_allowin64, ms_to_ws_valid64, ms_flush64, data_ok64, fwd_busy64;
  logic [104:0] es_bus64;
  logic [101:0] ws_bus64;
  logic [63:0]  rdata64, fwd_data64;
  logic [4:0]   fwd_dest64;

  int n_asserts = 0;
  int n_fails   = 0;

  mem_stage_ldx #(.PC_W(32), .DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .reset(reset), .es_to_ms_valid(es_valid), .es_to_ms_bus(es_bus),
    .ms_allowin(ms_allowin), .ws_allowin(ws_allowin), .ms_to_ws_valid(ms_to_ws_valid),
    .ms_to_ws_bus(ws_bus), .ms_flush(ms_flush), .data_sram_data_ok(data_ok),
    .data_sram_rdata(rdata), .ms_fwd_dest(fwd_dest), .ms_fwd_data(fwd_data), .ms_fwd_busy(fwd_busy)
  );

  mem_stage_ldx #(.PC_W(32), .DATA_W(64), .REG_AW(5)) dut64 (
    .clk(clk), .reset(reset), .es_to_ms_valid(es_valid64), .es_to_ms_bus(es_bus64),
    .ms_allowin(ms_allowin64), .ws_allowin(ws_allowin64), .ms_to_ws_valid(ms_to_ws_valid64),
    .ms_to_ws_bus(ws_bus64), .ms_flush(ms_flush64), .data_sram_data_ok(data_ok64),
    .data_sram_rdata(rdata64), .ms_fwd_dest(fwd_dest64), .ms_fwd_data(fwd_data64), .ms_fwd_busy(fwd_busy64)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_asserts++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check(name, 64'(act), 64'(exp));
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    check(name, 64'(act), 64'(exp));
  endtask

  function automatic logic [72:0] mk_bus(input logic [31:0] pc, input logic [4:0] dest,
                                         input logic [31:0] addr, input logic [2:0] op);
    return {pc, 1'b1, dest, addr, op};
  endfunction

  // Enter one instruction into the 32-bit DUT (clears es_valid after one cycle)
  task automatic enter(input logic [31:0] pc, input logic [4:0] dest, input logic [31:0] addr,
                       input logic [2:0] op);
    @(negedge clk);
    es_valid = 1'b1;
    es_bus   = mk_bus(pc, dest, addr, op);
    @(negedge clk);
    es_valid = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [2:0]  op;
    logic [63:0] addr;
    logic [63:0] rdata;
    logic [63:0] exp;
  } vec64_t;

  vec_t   vecs[12];
  vec64_t vecs64[5];

  initial begin
    vecs[0]  = '{3'd0, 32'h0000_1234, 32'h0,          32'h0000_1234};
    vecs[1]  = '{3'd1, 32'h0000_1002, 32'h80FF_7F00, 32'hFFFF_FFFF};
    vecs[2]  = '{3'd2, 32'h0000_1002, 32'h80FF_7F00, 32'h0000_00FF};
    vecs[3]  = '{3'd1, 32'h0000_1001, 32'h80FF_7F00, 32'h0000_007F};
    vecs[4]  = '{3'd1, 32'h0000_1003, 32'h80FF_7F00, 32'hFFFF_FF80};
    vecs[5]  = '{3'd2, 32'h0000_1000, 32'h80FF_7F00, 32'h0000_0000};
    vecs[6]  = '{3'd3, 32'h0000_2002, 32'h8001_0000, 32'hFFFF_8001};
    vecs[7]  = '{3'd4, 32'h0000_2002, 32'h8001_0000, 32'h0000_8001};
    vecs[8]  = '{3'd3, 32'h0000_2000, 32'h8001_7FFE, 32'h0000_7FFE};
    vecs[9]  = '{3'd5, 32'h0000_3000, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[10] = '{3'd6, 32'h0000_3000, 32'hCAFE_F00D, 32'hCAFE_F00D};
    vecs[11] = '{3'd7, 32'h0000_3000, 32'h1234_5678, 32'h1234_5678};

    vecs64[0] = '{3'd7, 64'h0, 64'h8123_4567_89AB_CDEF, 64'h8123_4567_89AB_CDEF};
    vecs64[1] = '{3'd6, 64'h4, 64'h8123_4567_89AB_CDEF, 64'h0000_0000_8123_4567};
    vecs64[2] = '{3'd5, 64'h4, 64'h8123_4567_89AB_CDEF, 64'hFFFF_FFFF_8123_4567};
    vecs64[3] = '{3'd1, 64'h7, 64'h8123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FF81};
    vecs64[4] = '{3'd4, 64'h2, 64'h8123_4567_89AB_CDEF, 64'h0000_0000_0000_89AB};

    reset = 1'b1; es_valid = 1'b0; es_bus = '0; ws_allowin = 1'b1; ms_flush = 1'b0;
    data_ok = 1'b0; rdata = '0;
    es_valid64 = 1'b0; es_bus64 = '0; ws_allowin64 = 1'b1; ms_flush64 = 1'b0;
    data_ok64 = 1'b0; rdata64 = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check1("rst_allowin", ms_allowin, 1'b1);
    check1("rst_valid", ms_to_ws_valid, 1'b0);
    check("rst_bus", 64'(ws_bus), 64'd0);
    check("rst_fwd_dest", 64'(fwd_dest), 64'd0);
    check1("rst_busy", fwd_busy, 1'b0);

    // Table: each load gets its response one cycle after entry
    for (int i = 0; i < 12; i++) begin
      enter(32'(32'h100 + i * 4), 5'(i + 1), vecs[i].addr, vecs[i].op);
      if (vecs[i].op != 3'd0) begin
        #1;
        check1($sformatf("v%0d_busy", i), fwd_busy, 1'b1);
        check1($sformatf("v%0d_wait", i), ms_to_ws_valid, 1'b0);
        data_ok = 1'b1;
        rdata   = vecs[i].rdata;
      end
      #1;
      check1($sformatf("v%0d_valid", i), ms_to_ws_valid, 1'b1);
      check32($sformatf("v%0d_result", i), ws_bus[31:0], vecs[i].exp);
      check32($sformatf("v%0d_pc", i), ws_bus[69:38], 32'(32'h100 + i * 4));
      check($sformatf("v%0d_fwd_dest", i), 64'(fwd_dest), 64'(i + 1));
      check32($sformatf("v%0d_fwd_data", i), fwd_data, vecs[i].exp);
      @(negedge clk);
      data_ok = 1'b0;
      #1;
      check1($sformatf("v%0d_gone", i), ms_to_ws_valid, 1'b0);
    end

    // LB with the response two cycles late
    enter(32'h400, 5'd4, 32'h0000_0002, 3'd1);
    #1;
    check1("lb_late_busy", fwd_busy, 1'b1);
    check1("lb_late_allowin", ms_allowin, 1'b0);
    check1("lb_late_valid", ms_to_ws_valid, 1'b0);
    @(negedge clk);
    #1;
    check1("lb_late_busy2", fwd_busy, 1'b1);
    data_ok = 1'b1; rdata = 32'h80FF_7F00;
    #1;
    check1("lb_late_done", ms_to_ws_valid, 1'b1);
    check32("lb_late_result", ws_bus[31:0], 32'hFFFF_FFFF);
    @(negedge clk);
    data_ok = 1'b0;

    // Response arrives while WB stalls; rdata changes afterwards
    enter(32'h500, 5'd5, 32'h0, 3'd5);
    ws_allowin = 1'b0; data_ok = 1'b1; rdata = 32'h1111_2222;
    #1;
    check1("stall_ready", ms_to_ws_valid, 1'b1);
    check1("stall_allowin", ms_allowin, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      data_ok = 1'b0; rdata = 32'h9999_9999;
      #1;
      check32($sformatf("stall_hold%0d", k), ws_bus[31:0], 32'h1111_2222);
      check1($sformatf("stall_busy%0d", k), fwd_busy, 1'b0);
    end
    @(negedge clk);
    ws_allowin = 1'b1;
    #1;
    check1("stall_valid", ms_to_ws_valid, 1'b1);
    check32("stall_result", ws_bus[31:0], 32'h1111_2222);
    @(negedge clk);
    #1;
    check1("stall_gone", ms_to_ws_valid, 1'b0);

    // Flush a pending load; its late response must be dropped
    enter(32'h600, 5'd6, 32'h0, 3'd5);
    ms_flush = 1'b1;
    #1;
    check1("flush_masked", ms_to_ws_valid, 1'b0);
    @(negedge clk);
    ms_flush = 1'b0;
    enter(32'h604, 5'd7, 32'h0, 3'd5);
    data_ok = 1'b1; rdata = 32'h0000_DEAD;
    #1;
    check1("drop_ignored", ms_to_ws_valid, 1'b0);
    check1("drop_busy", fwd_busy, 1'b1);
    @(negedge clk);
    rdata = 32'h0000_BEEF;
    #1;
    check1("drop_second_valid", ms_to_ws_valid, 1'b1);
    check32("drop_second_result", ws_bus[31:0], 32'h0000_BEEF);
    @(negedge clk);
    data_ok = 1'b0;

    // Flush with EX presenting: nothing captured
    enter(32'h700, 5'd7, 32'h77, 3'd0);
    es_valid = 1'b1; es_bus = mk_bus(32'h704, 5'd8, 32'h88, 3'd0); ms_flush = 1'b1;
    #1;
    check1("flush_es_masked", ms_to_ws_valid, 1'b0);
    @(negedge clk);
    es_valid = 1'b0; ms_flush = 1'b0;
    #1;
    check1("flush_es_empty", ms_to_ws_valid, 1'b0);
    check1("flush_es_allowin", ms_allowin, 1'b1);

    // Flush and data_ok together: response consumed, nothing left to drop
    enter(32'h800, 5'd8, 32'h0, 3'd5);
    ms_flush = 1'b1; data_ok = 1'b1; rdata = 32'h1;
    @(negedge clk);
    ms_flush = 1'b0; data_ok = 1'b0;
    enter(32'h804, 5'd9, 32'h0, 3'd5);
    data_ok = 1'b1; rdata = 32'h55;
    #1;
    check1("fd_next_valid", ms_to_ws_valid, 1'b1);
    check32("fd_next_result", ws_bus[31:0], 32'h55);
    @(negedge clk);
    data_ok = 1'b0;

    // Flush with the buffer holding data: buffer must not leak to the next load
    enter(32'h900, 5'd10, 32'h0, 3'd5);
    ws_allowin = 1'b0; data_ok = 1'b1; rdata = 32'h66;
    @(negedge clk);
    data_ok = 1'b0; ms_flush = 1'b1;
    @(negedge clk);
    ms_flush = 1'b0; ws_allowin = 1'b1;
    enter(32'h904, 5'd11, 32'h0, 3'd5);
    #1;
    check1("fb_busy", fwd_busy, 1'b1);
    check1("fb_wait", ms_to_ws_valid, 1'b0);
    data_ok = 1'b1; rdata = 32'h77;
    #1;
    check32("fb_result", ws_bus[31:0], 32'h77);
    @(negedge clk);
    data_ok = 1'b0;

    // Asynchronous reset with a buffered response
    enter(32'hA00, 5'd12, 32'h0, 3'd5);
    ws_allowin = 1'b0; data_ok = 1'b1; rdata = 32'hAB;
    @(negedge clk);
    data_ok = 1'b0;
    #1;
    check1("rr_buffered", ms_to_ws_valid, 1'b1);
    reset = 1'b1;
    #1;
    check1("rr_allowin", ms_allowin, 1'b1);
    check1("rr_valid", ms_to_ws_valid, 1'b0);
    check("rr_bus", 64'(ws_bus), 64'd0);
    check("rr_fwd_dest", 64'(fwd_dest), 64'd0);
    check1("rr_busy", fwd_busy, 1'b0);
    @(negedge clk);
    reset = 1'b0; ws_allowin = 1'b1;
    enter(32'hA04, 5'd13, 32'h0, 3'd5);
    #1;
    check1("rr_new_busy", fwd_busy, 1'b1);
    data_ok = 1'b1; rdata = 32'hCD;
    #1;
    check32("rr_new_result", ws_bus[31:0], 32'hCD);
    @(negedge clk);
    data_ok = 1'b0;

    // 64-bit instance table
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      es_valid64 = 1'b1;
      es_bus64   = {32'(32'hB00 + i * 4), 1'b1, 5'(i + 1), vecs64[i].addr, vecs64[i].op};
      @(negedge clk);
      es_valid64 = 1'b0; data_ok64 = 1'b1; rdata64 = vecs64[i].rdata;
      #1;
      check1($sformatf("w%0d_valid", i), ms_to_ws_valid64, 1'b1);
      check($sformatf("w%0d_result", i), ws_bus64[63:0], vecs64[i].exp);
      @(negedge clk);
      data_ok64 = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end
endmodule
